// File: rtl/write_back_pipe.sv
// ---------------------------------------------------------------------------
// write_back_pipe
//
// Registered MEM/WB write-back stage. Latches the MEM-stage results, picks
// the register-file write source (ALU result, memory data or PC+4 link
// address) and drives the register-file write port. These outputs also feed
// the forwarding unit. The stage provides stall/flush control, $zero write
// suppression and a retired-instruction counter.
//
// Optional feature: define WB_LOAD_EXT_EN to route the memory source through
// a sub-word load extender (byte/half lane select plus sign/zero extension).
// When the macro is undefined, memory data passes through unchanged and
// i_load_size / i_load_unsigned / i_addr_lsb are ignored.
//
// Parameters:
//   NB_DATA  datapath width (multiple of 16, at least 32 for sub-word lanes)
//   NB_ADDR  register index width
//   NB_CNT   retired-instruction counter width
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_valid           MEM stage holds a real instruction
//   i_stall, i_flush  hold all state / insert bubble (flush wins)
//   i_mem_data        raw word read from data memory
//   i_ALUresult       ALU result
//   i_pc_plus4        link address for JAL/JALR
//   i_reg2write       destination register index
//   i_wb_sel          00 ALU, 01 MEM, 10 PC+4, 11 reserved
//   i_regWrite        instruction writes a register
//   i_load_size       00 byte, 01 half, 1x word
//   i_load_unsigned   1 zero-extend, 0 sign-extend
//   i_addr_lsb        byte address bits [1:0] for lane select
//   o_write_data      data to register file
//   o_reg2write       destination register index
//   o_regWrite        register-file write enable
//   o_valid           WB stage holds a real instruction
//   o_retired_cnt     count of retired instructions (wraps silently)
// ---------------------------------------------------------------------------
module write_back_pipe #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_DATA-1:0] i_ALUresult,
    input  logic [NB_DATA-1:0] i_pc_plus4,
    input  logic [NB_ADDR-1:0] i_reg2write,
    input  logic [1:0]         i_wb_sel,
    input  logic               i_regWrite,
    input  logic [1:0]         i_load_size,
    input  logic               i_load_unsigned,
    input  logic [1:0]         i_addr_lsb,
    output logic [NB_DATA-1:0] o_write_data,
    output logic [NB_ADDR-1:0] o_reg2write,
    output logic               o_regWrite,
    output logic               o_valid,
    output logic [NB_CNT-1:0]  o_retired_cnt
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    logic [NB_DATA-1:0] mem_src;
    logic [NB_DATA-1:0] sel_data;

    logic               valid_q,    valid_d;
    logic               regwrite_q, regwrite_d;
    logic [NB_DATA-1:0] data_q,     data_d;
    logic [NB_ADDR-1:0] reg_q,      reg_d;
    logic [NB_CNT-1:0]  cnt_q,      cnt_d;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select: byte uses both address bits, half uses only bit 1.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        byte_lane = i_mem_data[7:0];
        case (i_addr_lsb)
            2'd0: byte_lane = i_mem_data[7:0];
            2'd1: byte_lane = i_mem_data[15:8];
            2'd2: byte_lane = i_mem_data[23:16];
            2'd3: byte_lane = i_mem_data[31:24];
            default: byte_lane = i_mem_data[7:0];
        endcase
        half_lane = i_addr_lsb[1] ? i_mem_data[31:16] : i_mem_data[15:0];

        mem_src = i_mem_data;
        if (i_load_size == 2'b00) begin
            mem_src = {{(NB_DATA-8){~i_load_unsigned & byte_lane[7]}}, byte_lane};
        end else if (i_load_size == 2'b01) begin
            mem_src = {{(NB_DATA-16){~i_load_unsigned & half_lane[15]}}, half_lane};
        end
    end
`else
    // Sub-word controls have no effect in this build; the ports stay for a
    // uniform interface.
    assign mem_src = i_mem_data;

    logic unused_load_ctrl;
    assign unused_load_ctrl = &{1'b0, i_load_size, i_load_unsigned, i_addr_lsb};
`endif

    // Write-source mux; the reserved encoding writes zero.
    always_comb begin
        sel_data = '0;
        case (wb_sel_e'(i_wb_sel))
            WB_ALU:  sel_data = i_ALUresult;
            WB_MEM:  sel_data = mem_src;
            WB_LINK: sel_data = i_pc_plus4;
            WB_RSVD: sel_data = '0;
            default: sel_data = '0;
        endcase
    end

    // Next state: flush > stall > capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        data_d     = data_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;

        if (i_flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            data_d     = '0;
            reg_d      = '0;
        end else if (!i_stall) begin
            valid_d    = i_valid;
            reg_d      = i_reg2write;
            data_d     = sel_data;
            // Writes to $zero and the reserved source never reach the file.
            regwrite_d = i_valid && i_regWrite && (i_reg2write != '0)
                         && (i_wb_sel != WB_RSVD);
            if (i_valid) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            data_q     <= '0;
            reg_q      <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            data_q     <= data_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_regWrite    = regwrite_q;
    assign o_write_data  = data_q;
    assign o_reg2write   = reg_q;
    assign o_retired_cnt = cnt_q;

endmodule

// File: tb/tb_write_back_pipe.sv
// ---------------------------------------------------------------------------
// tb_write_back_pipe
//
// Directed bench for write_back_pipe. A second instance with a 4-bit
// counter shares every input and is used to observe counter wrap-around.
// Expected values for the memory path depend on WB_LOAD_EXT_EN.
// ---------------------------------------------------------------------------
module tb_write_back_pipe;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic        reg_write;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  addr_lsb;

    logic [31:0] write_data;
    logic [4:0]  reg2write;
    logic        we;
    logic        vld;
    logic [31:0] cnt;

    logic [31:0] write_data_w;
    logic [4:0]  reg2write_w;
    logic        we_w;
    logic        vld_w;
    logic [3:0]  cnt_w;

    int checks = 0;
    int errors = 0;

    // {valid, we, rd, data, cnt}
    logic [70:0] obs;
    assign obs = {vld, we, reg2write, write_data, cnt};

    write_back_pipe #(.NB_DATA(32), .NB_ADDR(5), .NB_CNT(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
        .i_flush(flush), .i_mem_data(mem_data), .i_ALUresult(alu_result),
        .i_pc_plus4(pc_plus4), .i_reg2write(rd), .i_wb_sel(wb_sel),
        .i_regWrite(reg_write), .i_load_size(load_size),
        .i_load_unsigned(load_unsigned), .i_addr_lsb(addr_lsb),
        .o_write_data(write_data), .o_reg2write(reg2write),
        .o_regWrite(we), .o_valid(vld), .o_retired_cnt(cnt)
    );

    write_back_pipe #(.NB_DATA(32), .NB_ADDR(5), .NB_CNT(4)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
        .i_flush(flush), .i_mem_data(mem_data), .i_ALUresult(alu_result),
        .i_pc_plus4(pc_plus4), .i_reg2write(rd), .i_wb_sel(wb_sel),
        .i_regWrite(reg_write), .i_load_size(load_size),
        .i_load_unsigned(load_unsigned), .i_addr_lsb(addr_lsb),
        .o_write_data(write_data_w), .o_reg2write(reg2write_w),
        .o_regWrite(we_w), .o_valid(vld_w), .o_retired_cnt(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] r,
                         input logic w);
        valid     = v;
        wb_sel    = sel;
        rd        = r;
        reg_write = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_data = '0; alu_result = '0; pc_plus4 = '0;
        rd = '0; wb_sel = 2'b00; reg_write = 1'b0;
        load_size = 2'b10; load_unsigned = 1'b0; addr_lsb = 2'b00;
        #2;
        if (obs !== 71'h0) begin
            $display("FAIL reset_state got %h want %h", obs, 71'h0);
            errors++;
        end
        checks++;
        step();
        step();
        rst_n = 1'b1;  // released between edges
    endtask

    task automatic test_alu_path();
        drive(1'b1, 2'b00, 5'd5, 1'b1);
        alu_result = 32'h0000_1234;
        step();
        if (obs !== {1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'd1}) begin
            $display("FAIL alu_path got %h want %h", obs,
                     {1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'd1});
            errors++;
        end
        checks++;
    endtask

    task automatic test_load_ext();
        logic [31:0] exp_b, exp_h;
`ifdef WB_LOAD_EXT_EN
        exp_b = 32'hFFFF_FF80;
        exp_h = 32'h0000_80FF;
`else
        exp_b = 32'h80FF_7F01;
        exp_h = 32'h80FF_7F01;
`endif
        drive(1'b1, 2'b01, 5'd6, 1'b1);
        mem_data = 32'h80FF_7F01;
        load_size = 2'b00; load_unsigned = 1'b0; addr_lsb = 2'd3;
        step();
        if (obs !== {1'b1, 1'b1, 5'd6, exp_b, 32'd2}) begin
            $display("FAIL load_byte got %h want %h", obs, {1'b1, 1'b1, 5'd6, exp_b, 32'd2});
            errors++;
        end
        checks++;

        load_size = 2'b01; load_unsigned = 1'b1; addr_lsb = 2'd2;
        step();
        if (obs !== {1'b1, 1'b1, 5'd6, exp_h, 32'd3}) begin
            $display("FAIL load_half got %h want %h", obs, {1'b1, 1'b1, 5'd6, exp_h, 32'd3});
            errors++;
        end
        checks++;

        load_size = 2'b10; load_unsigned = 1'b0; addr_lsb = 2'd1;
        step();
        if (obs !== {1'b1, 1'b1, 5'd6, 32'h80FF_7F01, 32'd4}) begin
            $display("FAIL load_word got %h want %h", obs,
                     {1'b1, 1'b1, 5'd6, 32'h80FF_7F01, 32'd4});
            errors++;
        end
        checks++;
    endtask

    task automatic test_zero_reserved();
        drive(1'b1, 2'b00, 5'd0, 1'b1);
        alu_result = 32'h0000_ABCD;
        step();
        if (obs !== {1'b1, 1'b0, 5'd0, 32'h0000_ABCD, 32'd5}) begin
            $display("FAIL zero_dest got %h want %h", obs,
                     {1'b1, 1'b0, 5'd0, 32'h0000_ABCD, 32'd5});
            errors++;
        end
        checks++;

        drive(1'b1, 2'b11, 5'd4, 1'b1);
        step();
        if (obs !== {1'b1, 1'b0, 5'd4, 32'h0, 32'd6}) begin
            $display("FAIL reserved_sel got %h want %h", obs, {1'b1, 1'b0, 5'd4, 32'h0, 32'd6});
            errors++;
        end
        checks++;
    endtask

    task automatic test_link_and_invalid();
        drive(1'b0, 2'b10, 5'd7, 1'b1);
        pc_plus4 = 32'h0000_0100;
        step();
        if (obs !== {1'b0, 1'b0, 5'd7, 32'h0000_0100, 32'd6}) begin
            $display("FAIL invalid_capture got %h want %h", obs,
                     {1'b0, 1'b0, 5'd7, 32'h0000_0100, 32'd6});
            errors++;
        end
        checks++;

        drive(1'b1, 2'b10, 5'd31, 1'b1);
        pc_plus4 = 32'h0000_4008;
        step();
        if (obs !== {1'b1, 1'b1, 5'd31, 32'h0000_4008, 32'd7}) begin
            $display("FAIL link_path got %h want %h", obs,
                     {1'b1, 1'b1, 5'd31, 32'h0000_4008, 32'd7});
            errors++;
        end
        checks++;
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 2'b00, 5'd9, 1'b1);
        alu_result = 32'h0000_0055;
        step();
        if (obs !== {1'b1, 1'b1, 5'd9, 32'h0000_0055, 32'd8}) begin
            $display("FAIL pre_stall got %h want %h", obs,
                     {1'b1, 1'b1, 5'd9, 32'h0000_0055, 32'd8});
            errors++;
        end
        checks++;

        // New instruction presented while stalled must not be taken.
        stall = 1'b1;
        drive(1'b1, 2'b00, 5'd12, 1'b1);
        alu_result = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs !== {1'b1, 1'b1, 5'd9, 32'h0000_0055, 32'd8}) begin
                $display("FAIL stall_hold_%0d got %h want %h", i, obs,
                         {1'b1, 1'b1, 5'd9, 32'h0000_0055, 32'd8});
                errors++;
            end
            checks++;
        end

        flush = 1'b1;
        step();
        if (obs !== {1'b0, 1'b0, 5'd0, 32'h0, 32'd8}) begin
            $display("FAIL flush_bubble got %h want %h", obs, {1'b0, 1'b0, 5'd0, 32'h0, 32'd8});
            errors++;
        end
        checks++;
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        drive(1'b1, 2'b00, 5'd3, 1'b1);
        alu_result = 32'h0000_0777;
        step();
        if (obs !== {1'b1, 1'b1, 5'd3, 32'h0000_0777, 32'd9}) begin
            $display("FAIL pre_reset got %h want %h", obs,
                     {1'b1, 1'b1, 5'd3, 32'h0000_0777, 32'd9});
            errors++;
        end
        checks++;

        #2 rst_n = 1'b0;
        #1;
        if (obs !== 71'h0 || cnt_w !== 4'd0) begin
            $display("FAIL reset_mid got %h cnt_w %0d want %h cnt_w 0", obs, cnt_w, 71'h0);
            errors++;
        end
        checks++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        drive(1'b1, 2'b00, 5'd1, 1'b1);
        alu_result = 32'h0000_0001;
        for (int i = 0; i < 15; i++) step();
        if (cnt_w !== 4'd15) begin
            $display("FAIL cnt_pre_wrap got %0d want 15", cnt_w);
            errors++;
        end
        checks++;
        step();
        step();
        if (cnt_w !== 4'd1 || cnt !== 32'd17) begin
            $display("FAIL cnt_wrap got cnt_w %0d cnt %0d want cnt_w 1 cnt 17", cnt_w, cnt);
            errors++;
        end
        checks++;
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_path();
        test_load_ext();
        test_zero_reserved();
        test_link_and_invalid();
        test_stall_flush();
        test_reset_mid_stream();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
